// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: bus widths, response codes and the master state encoding.
// Used by the LSU data-port master and its bench.
package axi_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } mst_state_e;

  // EXOKAY is only meaningful for exclusive accesses, which this master never issues.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/lsu_axi_master.sv
// AXI-lite master turning single LSU load/store requests into AR/R or AW/W/B transactions.
// One transaction outstanding; every bus-facing output comes straight from a flop.
module lsu_axi_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,

  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,

  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  mst_state_e        state;
  logic [ADDR_W-1:0] addr_q;
  logic              aw_done;
  logic              w_done;
  logic              aw_fire;
  logic              w_fire;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  // Both channels share the captured address; only one of them is ever valid.
  assign araddr = addr_q;
  assign awaddr = addr_q;

  // Transaction sequencer; req_ready is kept as a flop mirroring state == ST_IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      addr_q     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            if (req_we) begin
              wdata   <= req_wdata;
              wstrb   <= req_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= ST_WR_REQ;
            end else begin
              arvalid <= 1'b1;
              state   <= ST_RD_ADDR;
            end
          end
        end

        ST_RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (rvalid) begin
            rready     <= 1'b0;
            resp_rdata <= rdata;
            resp_err   <= resp_is_err(rresp);
            resp_valid <= 1'b1;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end

        ST_WR_REQ: begin
          if (aw_fire) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          // Same-cycle completion of the second channel must count as done here.
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            bready <= 1'b1;
            state  <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_err   <= resp_is_err(bresp);
            resp_valid <= 1'b1;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end

        default: begin
          arvalid   <= 1'b0;
          rready    <= 1'b0;
          awvalid   <= 1'b0;
          wvalid    <= 1'b0;
          bready    <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
